vram_slot_arbiter: RTL and testbench

- Shares one single-port synchronous video RAM between the CPU and the playfield/motion-object fetch sequencer.
- Time-slot scheduled from the low horizontal-chain phase bits (6MHz/1H/2H), so video fetch keeps a fixed cadence during active display.
- During vblank the CPU gets every slot video leaves idle.
- Sits between the H/V timing chain, the CPU bus interface and the video RAM macro.

---
 rtl/video_arb_pkg.sv | 13 +
 rtl/vram_rd_pipe.sv | 47 ++++
 rtl/vram_slot_arbiter.sv | 125 ++++++++++++
 tb/tb_vram_slot_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_arb_pkg.sv
// Shared types and constants for the video RAM slot arbiter and its read pipeline.
package video_arb_pkg;

   typedef enum logic [1:0] {OWN_NONE, OWN_VID, OWN_CPU} owner_t;

   typedef enum logic [1:0] {C_IDLE, C_WAIT, C_FLIGHT, C_ACK} cpu_state_t;

   localparam logic [7:0] DEF_CPU_SLOT_MASK = 8'b1100_0000;
   localparam int         FIXED_LATENCY     = 3;
   // Cycles the CPU FSM spends in C_FLIGHT between grant and ack.
   localparam int         FLIGHT_CYCLES     = FIXED_LATENCY - 1;

endpackage

// File: rtl/vram_rd_pipe.sv
// Owner-tag shift register that follows each RAM access and routes the captured
// read data to the video or CPU side three cycles after the grant.
module vram_rd_pipe
   import video_arb_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  owner_t        issue_owner,
   input  logic          issue_we,
   input  logic [DW-1:0] ram_rdata,
   output logic          vid_valid,
   output logic [DW-1:0] vid_data,
   output logic          cpu_ack,
   output logic [DW-1:0] cpu_rdata
);

   owner_t tag0, tag1;
   logic   we0, we1;

   // tag1 lines up with ram_rdata; writes still ack but leave cpu_rdata untouched.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tag0      <= OWN_NONE;
         tag1      <= OWN_NONE;
         we0       <= 1'b0;
         we1       <= 1'b0;
         vid_valid <= 1'b0;
         vid_data  <= '0;
         cpu_ack   <= 1'b0;
         cpu_rdata <= '0;
      end else begin
         tag0      <= issue_owner;
         we0       <= issue_we;
         tag1      <= tag0;
         we1       <= we0;
         vid_valid <= (tag1 == OWN_VID);
         cpu_ack   <= (tag1 == OWN_CPU);
         if (tag1 == OWN_VID)
            vid_data <= ram_rdata;
         if (tag1 == OWN_CPU && !we1)
            cpu_rdata <= ram_rdata;
      end
   end

endmodule

// File: rtl/vram_slot_arbiter.sv
// Time-slot arbiter sharing one single-port video RAM between the CPU and the
// video fetch sequencer; slots come from the low horizontal-chain phase bits.
module vram_slot_arbiter
   import video_arb_pkg::*;
#(
   parameter int         AW            = 10,
   parameter int         DW            = 8,
   parameter logic [7:0] CPU_SLOT_MASK = DEF_CPU_SLOT_MASK,
   parameter int         MAX_WAIT      = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [2:0]    h_phase,
   input  logic          vblank,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_ack,
   output logic [DW-1:0] cpu_rdata,
   input  logic          vid_req,
   input  logic [AW-1:0] vid_addr,
   output logic          vid_valid,
   output logic [DW-1:0] vid_data,
   output logic          vid_miss,
   output logic [AW-1:0] ram_addr,
   output logic          ram_we,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata
);

   // CPU handshake: cpu_req stays high until the one-cycle cpu_ack pulse; the
   // address/data are sampled in the grant cycle, and a req still high in the
   // cycle after cpu_ack starts a fresh access.

   cpu_state_t state, state_nx;
   logic [1:0] flight_cnt;
   logic [7:0] wait_cnt;
   logic       cpu_waiting, in_cpu_slot, force_grant;
   logic       cpu_grant, vid_grant, vid_miss_nx;
   owner_t     issue_owner;

   assign cpu_waiting = (state == C_WAIT);
   assign in_cpu_slot = CPU_SLOT_MASK[h_phase];
   assign force_grant = cpu_waiting && (wait_cnt == 8'(MAX_WAIT));

   always_comb begin
      cpu_grant   = 1'b0;
      vid_grant   = 1'b0;
      vid_miss_nx = 1'b0;
      if (force_grant) begin
         cpu_grant   = 1'b1;
         // A CPU slot would have refused video anyway, so only count real losses.
         vid_miss_nx = vid_req && (vblank || !in_cpu_slot);
      end else if (!vblank && in_cpu_slot) begin
         cpu_grant = cpu_waiting;
         vid_grant = !cpu_waiting && vid_req;
      end else if (vid_req) begin
         vid_grant = 1'b1;
      end else if (vblank) begin
         cpu_grant = cpu_waiting;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         C_IDLE:   if (cpu_req) state_nx = C_WAIT;
         C_WAIT:   if (cpu_grant) state_nx = C_FLIGHT;
         C_FLIGHT: if (flight_cnt == 2'(FLIGHT_CYCLES - 1)) state_nx = C_ACK;
         C_ACK:    state_nx = C_IDLE;
         default:  state_nx = C_IDLE;
      endcase
   end

   always_comb begin
      issue_owner = OWN_NONE;
      if (cpu_grant)
         issue_owner = OWN_CPU;
      else if (vid_grant)
         issue_owner = OWN_VID;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= C_IDLE;
         flight_cnt <= '0;
         wait_cnt   <= '0;
         vid_miss   <= 1'b0;
         ram_addr   <= '0;
         ram_we     <= 1'b0;
         ram_wdata  <= '0;
      end else begin
         state      <= state_nx;
         flight_cnt <= (state == C_FLIGHT) ? flight_cnt + 2'd1 : 2'd0;
         vid_miss   <= vid_miss_nx;
         if (!cpu_waiting || cpu_grant)
            wait_cnt <= '0;
         else if (wait_cnt != 8'(MAX_WAIT))
            wait_cnt <= wait_cnt + 8'd1;
         // Idle cycles keep the last address on the RAM bus.
         ram_we <= 1'b0;
         if (cpu_grant) begin
            ram_addr  <= cpu_addr;
            ram_we    <= cpu_we;
            ram_wdata <= cpu_wdata;
         end else if (vid_grant) begin
            ram_addr <= vid_addr;
         end
      end
   end

   vram_rd_pipe #(.DW(DW)) u_rd_pipe (
      .clk         (clk),
      .reset       (reset),
      .issue_owner (issue_owner),
      .issue_we    (cpu_grant && cpu_we),
      .ram_rdata   (ram_rdata),
      .vid_valid   (vid_valid),
      .vid_data    (vid_data),
      .cpu_ack     (cpu_ack),
      .cpu_rdata   (cpu_rdata)
   );

endmodule

// File: tb/tb_vram_slot_arbiter.sv
// Directed bench for vram_slot_arbiter: two instances (default slots, and
// no CPU slots with a short forced-grant timeout) each with its own RAM model.
module tb_vram_slot_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  h_phase;
   logic        vblank;
   logic        cpu_we;
   logic [9:0]  cpu_addr;
   logic [7:0]  cpu_wdata;
   logic [9:0]  vid_addr;

   logic        cpu_req, vid_req;
   logic        cpu_ack, vid_valid, vid_miss, ram_we;
   logic [7:0]  cpu_rdata, vid_data, ram_wdata, ram_rdata;
   logic [9:0]  ram_addr;

   logic        cpu_req_f, vid_req_f;
   logic        cpu_ack_f, vid_valid_f, vid_miss_f, ram_we_f;
   logic [7:0]  cpu_rdata_f, vid_data_f, ram_wdata_f, ram_rdata_f;
   logic [9:0]  ram_addr_f;

   logic [31:0] cyc = 32'd0;
   int          n_cmp = 0;
   int          n_err = 0;
   int          miss_f_cnt = 0;
   logic [31:0] miss_f_cyc = 32'd0;

   // Expected entries are {output cycle[31:0], data[7:0]}.
   logic [39:0] exp_vid_q[$];
   logic [39:0] exp_cpu_q[$];
   logic [39:0] exp_cpu_f_q[$];

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 32'd1;

   // ---------------- DUTs and RAM models ----------------
   vram_slot_arbiter dut (
      .clk(clk), .reset(reset), .h_phase(h_phase), .vblank(vblank),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_valid(vid_valid), .vid_data(vid_data),
      .vid_miss(vid_miss), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   vram_slot_arbiter #(.CPU_SLOT_MASK(8'h00), .MAX_WAIT(4)) dut_f (
      .clk(clk), .reset(reset), .h_phase(h_phase), .vblank(vblank),
      .cpu_req(cpu_req_f), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack_f), .cpu_rdata(cpu_rdata_f),
      .vid_req(vid_req_f), .vid_addr(vid_addr), .vid_valid(vid_valid_f), .vid_data(vid_data_f),
      .vid_miss(vid_miss_f), .ram_addr(ram_addr_f), .ram_we(ram_we_f), .ram_wdata(ram_wdata_f),
      .ram_rdata(ram_rdata_f)
   );

   function automatic logic [7:0] pat(input logic [9:0] a);
      return a[7:0] ^ 8'h3C;
   endfunction

   function automatic logic [7:0] init_val(input int i);
      logic [9:0] a;
      a = 10'(i);
      return (a == 10'h123) ? 8'hA5 : pat(a);
   endfunction

   logic [7:0] mem   [1024];
   logic [7:0] mem_f [1024];
   logic       mem_ready = 1'b0;

   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 1024; i++) begin
            mem[i]   <= init_val(i);
            mem_f[i] <= init_val(i);
         end
         ram_rdata   <= 8'h00;
         ram_rdata_f <= 8'h00;
         mem_ready   <= 1'b1;
      end else begin
         if (ram_we)   mem[ram_addr]     <= ram_wdata;
         if (ram_we_f) mem_f[ram_addr_f] <= ram_wdata_f;
         ram_rdata   <= mem[ram_addr];
         ram_rdata_f <= mem_f[ram_addr_f];
      end
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string nm, input logic [39:0] act, input logic [39:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      logic [39:0] e;
      if (vid_valid) begin
         if (exp_vid_q.size() == 0) check("vid_spurious_valid", 40'(vid_valid), 40'd0);
         else begin e = exp_vid_q.pop_front(); check("vid_out", {cyc, vid_data}, e); end
      end
      if (exp_vid_q.size() > 0 && exp_vid_q[0][39:8] < cyc) begin
         e = exp_vid_q.pop_front();
         check("vid_missing", {cyc, vid_data}, e);
      end
      if (cpu_ack) begin
         if (exp_cpu_q.size() == 0) check("cpu_spurious_ack", 40'(cpu_ack), 40'd0);
         else begin e = exp_cpu_q.pop_front(); check("cpu_out", {cyc, cpu_rdata}, e); end
      end
      if (exp_cpu_q.size() > 0 && exp_cpu_q[0][39:8] < cyc) begin
         e = exp_cpu_q.pop_front();
         check("cpu_missing", {cyc, cpu_rdata}, e);
      end
      if (cpu_ack_f) begin
         if (exp_cpu_f_q.size() == 0) check("cpuf_spurious_ack", 40'(cpu_ack_f), 40'd0);
         else begin e = exp_cpu_f_q.pop_front(); check("cpuf_out", {cyc, cpu_rdata_f}, e); end
      end
      if (exp_cpu_f_q.size() > 0 && exp_cpu_f_q[0][39:8] < cyc) begin
         e = exp_cpu_f_q.pop_front();
         check("cpuf_missing", {cyc, cpu_rdata_f}, e);
      end
      if (vid_miss) check("vid_miss_main", 40'(vid_miss), 40'd0);
      if (vid_miss_f) begin
         miss_f_cnt++;
         miss_f_cyc = cyc;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      h_phase = h_phase + 3'd1;
   endtask

   task automatic align_to(input logic [2:0] p);
      for (int i = 0; i < 8 && h_phase != p; i++) tick();
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_ram_addr"},  40'(ram_addr),  40'd0);
      check({tag, "_ram_we"},    40'(ram_we),    40'd0);
      check({tag, "_ram_wdata"}, 40'(ram_wdata), 40'd0);
      check({tag, "_cpu_ack"},   40'(cpu_ack),   40'd0);
      check({tag, "_cpu_rdata"}, 40'(cpu_rdata), 40'd0);
      check({tag, "_vid_valid"}, 40'(vid_valid), 40'd0);
      check({tag, "_vid_data"},  40'(vid_data),  40'd0);
      check({tag, "_vid_miss"},  40'(vid_miss),  40'd0);
   endtask

   // Single CPU access with no video traffic during vblank: grant in the first C_WAIT cycle.
   task automatic cpu_op(input logic we, input logic [9:0] a, input logic [7:0] d,
                         input logic [7:0] exp_rd);
      tick(); cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
      tick(); exp_cpu_q.push_back({cyc + 32'd3, exp_rd});
      tick();
      check("op_ram_addr",  40'(ram_addr),  40'(a));
      check("op_ram_we",    40'(ram_we),    40'(we));
      check("op_ram_wdata", 40'(ram_wdata), 40'(d));
      tick(); check("op_we_one_cycle", 40'(ram_we), 40'd0);
      tick();
      tick(); cpu_req = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int acks;
      logic [31:0] g_f;
      reset = 1'b1; h_phase = 3'd0; vblank = 1'b0;
      cpu_req = 1'b0; vid_req = 1'b0; cpu_req_f = 1'b0; vid_req_f = 1'b0;
      cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; vid_addr = '0;

      // Reset state, then reset in the middle of a CPU access.
      repeat (3) tick();
      check_outputs_zero("rst");
      tick(); reset = 1'b0; vblank = 1'b1;
      tick(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h010;
      tick();
      tick(); check("pre_rst_ram_addr", 40'(ram_addr), 40'h010);
      reset = 1'b1;
      #1;
      check_outputs_zero("midrst");
      cpu_req = 1'b0;
      tick(); tick(); reset = 1'b0;
      acks = 0;
      repeat (6) begin tick(); acks += int'(cpu_ack); end
      check("no_ack_after_rst", 40'(acks), 40'd0);

      // Active display, video every cycle, CPU read raised at phase 2.
      vblank = 1'b0;
      align_to(3'd0);
      for (int k = 0; k < 16; k++) begin
         if (k != 0) tick();
         vid_req = 1'b1;
         vid_addr = 10'h200 + 10'(k);
         if (k != 6) exp_vid_q.push_back({cyc + 32'd3, pat(vid_addr)});
         if (k == 2) begin cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h123; end
         if (k == 6) exp_cpu_q.push_back({cyc + 32'd3, 8'hA5});
         if (k == 7) begin
            check("b_ram_addr_cpu", 40'(ram_addr), 40'h123);
            check("b_ram_we_read",  40'(ram_we),   40'd0);
         end
         if (k == 8) check("b_ram_addr_vid7", 40'(ram_addr), 40'h207);
         if (k == 10) cpu_req = 1'b0;
      end
      tick(); vid_req = 1'b0;
      repeat (4) tick();

      // Vblank write then readback.
      vblank = 1'b1;
      cpu_op(1'b1, 10'h3FF, 8'h5A, 8'hA5);
      cpu_op(1'b0, 10'h3FF, 8'h00, 8'h5A);

      // cpu_req held across ack: second access starts the cycle after ack.
      tick(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h123;
      tick(); exp_cpu_q.push_back({cyc + 32'd3, 8'hA5});
      tick(); check("d_ram_addr1", 40'(ram_addr), 40'h123);
      tick();
      tick(); cpu_addr = 10'h3FF;
      tick();
      tick(); exp_cpu_q.push_back({cyc + 32'd3, 8'h5A});
      tick(); check("d_ram_addr2", 40'(ram_addr), 40'h3FF);
      tick();
      tick();
      tick(); cpu_req = 1'b0;
      repeat (4) tick();

      // Vblank rises on a non-CPU slot while the CPU waits.
      vblank = 1'b0;
      align_to(3'd0);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h200;
      tick();
      tick();
      tick(); vblank = 1'b1;
      check("e_no_early_grant", 40'(ram_addr), 40'h3FF);
      exp_cpu_q.push_back({cyc + 32'd3, pat(10'h200)});
      tick(); check("e_ram_addr", 40'(ram_addr), 40'h200);
      tick();
      tick();
      tick(); cpu_req = 1'b0;
      repeat (3) tick();

      // Forced grant on the no-CPU-slot instance with continuous video.
      vblank = 1'b0;
      tick(); cpu_req_f = 1'b1; vid_req_f = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h123; vid_addr = 10'h210;
      miss_f_cnt = 0;
      repeat (5) tick();
      g_f = cyc;
      exp_cpu_f_q.push_back({cyc + 32'd3, 8'hA5});
      tick(); check("f_ram_addr", 40'(ram_addr_f), 40'h123);
      tick();
      tick();
      tick(); cpu_req_f = 1'b0; vid_req_f = 1'b0;
      repeat (4) tick();
      check("f_miss_count", 40'(miss_f_cnt), 40'd1);
      check("f_miss_cycle", 40'(miss_f_cyc), 40'(g_f + 32'd1));

      check("drain_vid",   40'(exp_vid_q.size()),   40'd0);
      check("drain_cpu",   40'(exp_cpu_q.size()),   40'd0);
      check("drain_cpu_f", 40'(exp_cpu_f_q.size()), 40'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

endmodule
